fme_mv_refine: RTL and testbench

- Downstream consumer of the 9-candidate SATD stage in the FME path.
- Takes an integer-pel motion vector from IME and runs a two-pass refinement, each pass on a 3x3 grid:
  - first pass at half-pel, around the integer MV;
  - second pass at quarter-pel, around the winning half-pel position.
- Each pass starts the SATD stage and waits for its `best` index and `done`.
- Maps the winning index to an offset and emits the final quarter-pel MV through a valid/ready handshake to the mode-decision stage.

---
 rtl/fme_mv_refine_pkg.sv | 16 +
 rtl/fme_mv_refine_idx2off.sv | 34 +++
 rtl/fme_mv_refine.sv | 124 ++++++++++++
 tb/tb_fme_mv_refine.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fme_mv_refine_pkg.sv
// Shared definitions for the fractional-motion-estimation refinement path.
package fme_mv_refine_pkg;

   typedef enum logic [2:0] {
      IDLE,
      H_START,
      H_WAIT,
      Q_START,
      Q_WAIT,
      OUT
   } state_e;

   localparam int CENTRE_IDX = 4;
   localparam int NUM_CAND   = 9;

endpackage

// File: rtl/fme_mv_refine_idx2off.sv
// Maps a 3x3 candidate index to a signed (dx,dy) offset in the range -1..+1.
// Out-of-range indices fall back to the centre and raise the illegal flag.
module fme_idx2off
   import fme_mv_refine_pkg::*;
(
   input  logic [3:0]        idx,
   output logic signed [1:0] dx,
   output logic signed [1:0] dy,
   output logic              illegal
);

   logic [3:0] idx_eff;

   // Row-major grid: column gives dx, row gives dy, index 4 is the centre.
   always_comb begin
      illegal = (idx >= 4'(NUM_CAND));
      idx_eff = illegal ? 4'(CENTRE_IDX) : idx;
      dx      = 2'sd0;
      dy      = 2'sd0;
      case (idx_eff)
         4'd0: begin dx = -2'sd1; dy = -2'sd1; end
         4'd1: begin dx =  2'sd0; dy = -2'sd1; end
         4'd2: begin dx =  2'sd1; dy = -2'sd1; end
         4'd3: begin dx = -2'sd1; dy =  2'sd0; end
         4'd4: begin dx =  2'sd0; dy =  2'sd0; end
         4'd5: begin dx =  2'sd1; dy =  2'sd0; end
         4'd6: begin dx = -2'sd1; dy =  2'sd1; end
         4'd7: begin dx =  2'sd0; dy =  2'sd1; end
         4'd8: begin dx =  2'sd1; dy =  2'sd1; end
         default: begin dx = 2'sd0; dy = 2'sd0; end
      endcase
   end

endmodule

// File: rtl/fme_mv_refine.sv
// Two-pass (half-pel then quarter-pel) motion-vector refinement around an
// integer-pel MV, driving the 9-candidate SATD stage once per pass.
module fme_mv_refine
   import fme_mv_refine_pkg::*;
#(
   parameter int MV_W    = 10,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mv_valid,
   output logic                   mv_ready,
   input  logic signed [MV_W-1:0] mv_int_x,
   input  logic signed [MV_W-1:0] mv_int_y,
   output logic                   satd_start,
   output logic                   satd_phase,
   output logic signed [MV_W+1:0] ctr_x,
   output logic signed [MV_W+1:0] ctr_y,
   input  logic [3:0]             best,
   input  logic                   best_done,
   output logic signed [MV_W+1:0] mv_out_x,
   output logic signed [MV_W+1:0] mv_out_y,
   output logic                   mv_out_valid,
   input  logic                   mv_out_ready,
   output logic                   err
);

   localparam int CW = MV_W + 2;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic signed [CW-1:0]   ctr_x_q, ctr_x_d;
   logic signed [CW-1:0]   ctr_y_q, ctr_y_d;
   logic                   err_q, err_d;

   logic signed [1:0]      off_x, off_y;
   logic                   idx_illegal;
   logic signed [CW-1:0]   off_x_ext, off_y_ext;
   logic signed [CW-1:0]   step_x, step_y;

   fme_idx2off u_idx2off (
      .idx     (best),
      .dx      (off_x),
      .dy      (off_y),
      .illegal (idx_illegal)
   );

   assign off_x_ext = {{(CW-2){off_x[1]}}, off_x};
   assign off_y_ext = {{(CW-2){off_y[1]}}, off_y};

   // Half-pel pass moves two quarter-pel units per grid step, quarter pass one.
   assign step_x = (state_q == H_WAIT) ? {off_x_ext[CW-2:0], 1'b0} : off_x_ext;
   assign step_y = (state_q == H_WAIT) ? {off_y_ext[CW-2:0], 1'b0} : off_y_ext;

   // Next-state, centre accumulation, timeout counting and sticky error.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ctr_x_d = ctr_x_q;
      ctr_y_d = ctr_y_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (mv_valid) begin
               ctr_x_d = {mv_int_x, 2'b00};
               ctr_y_d = {mv_int_y, 2'b00};
               err_d   = 1'b0;
               state_d = H_START;
            end
         end
         H_START, Q_START: begin
            cnt_d   = '0;
            state_d = (state_q == H_START) ? H_WAIT : Q_WAIT;
         end
         H_WAIT, Q_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (best_done) begin
               ctr_x_d = ctr_x_q + step_x;
               ctr_y_d = ctr_y_q + step_y;
               err_d   = err_q | idx_illegal;
               state_d = (state_q == H_WAIT) ? Q_START : OUT;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = (state_q == H_WAIT) ? Q_START : OUT;
            end
         end
         OUT: begin
            if (mv_out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any job in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ctr_x_q <= '0;
         ctr_y_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctr_x_q <= ctr_x_d;
         ctr_y_q <= ctr_y_d;
         err_q   <= err_d;
      end
   end

   assign mv_ready     = (state_q == IDLE);
   assign satd_start   = (state_q == H_START) || (state_q == Q_START);
   assign satd_phase   = (state_q == Q_START) || (state_q == Q_WAIT);
   assign ctr_x        = ctr_x_q;
   assign ctr_y        = ctr_y_q;
   assign mv_out_valid = (state_q == OUT);
   assign mv_out_x     = (state_q == OUT) ? ctr_x_q : '0;
   assign mv_out_y     = (state_q == OUT) ? ctr_y_q : '0;
   assign err          = err_q;

endmodule

// File: tb/tb_fme_mv_refine.sv
// Randomised bench for fme_mv_refine against an arithmetic reference model.
module tb_fme_mv_refine;

   localparam int MV_W    = 10;
   localparam int TIMEOUT = 255;
   localparam int CNT_W   = 8;
   localparam int CW      = MV_W + 2;

   logic                   clk;
   logic                   rst;
   logic                   mv_valid;
   logic                   mv_ready;
   logic signed [MV_W-1:0] mv_int_x;
   logic signed [MV_W-1:0] mv_int_y;
   logic                   satd_start;
   logic                   satd_phase;
   logic signed [CW-1:0]   ctr_x;
   logic signed [CW-1:0]   ctr_y;
   logic [3:0]             best;
   logic                   best_done;
   logic signed [CW-1:0]   mv_out_x;
   logic signed [CW-1:0]   mv_out_y;
   logic                   mv_out_valid;
   logic                   mv_out_ready;
   logic                   err;

   int tests_run;
   int tests_failed;
   int pulse_cnt;
   bit phase_q[$];

   fme_mv_refine #(.MV_W(MV_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .mv_valid     (mv_valid),
      .mv_ready     (mv_ready),
      .mv_int_x     (mv_int_x),
      .mv_int_y     (mv_int_y),
      .satd_start   (satd_start),
      .satd_phase   (satd_phase),
      .ctr_x        (ctr_x),
      .ctr_y        (ctr_y),
      .best         (best),
      .best_done    (best_done),
      .mv_out_x     (mv_out_x),
      .mv_out_y     (mv_out_y),
      .mv_out_valid (mv_out_valid),
      .mv_out_ready (mv_out_ready),
      .err          (err)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count satd_start pulses and log their phase, sampled away from the edge.
   always @(negedge clk) begin
      if (satd_start) begin
         pulse_cnt = pulse_cnt + 1;
         phase_q.push_back(satd_phase);
      end
   end

   // Reference model: grid offset of a candidate index, illegal -> centre.
   function automatic int off_x(input int b);
      return (b > 8) ? 0 : (b % 3) - 1;
   endfunction

   function automatic int off_y(input int b);
      return (b > 8) ? 0 : (b / 3) - 1;
   endfunction

   // Observations captured by drive_job for the test tasks to judge.
   bit obs_err_start, obs_hs_start, obs_hs_phase, obs_qs_start, obs_qs_phase;
   bit obs_valid, obs_err, obs_stable, obs_after_valid, obs_after_ready;
   int obs_h_ctr_x, obs_h_ctr_y, obs_q_ctr_x, obs_q_ctr_y, obs_out_x, obs_out_y;
   int obs_pulses;

   // One full job. hdel/qdel are idle WAIT cycles before best_done; a value
   // of TIMEOUT or more withholds best_done for the whole pass.
   task automatic drive_job(input int mx, input int my, input int hb, input int qb,
                            input int hdel, input int qdel, input int rdel,
                            input bit done_in_start);
      int p0;
      int k;
      p0 = pulse_cnt;
      @(negedge clk);
      mv_valid = 1'b1;
      mv_int_x = MV_W'(mx);
      mv_int_y = MV_W'(my);
      @(posedge clk);
      @(negedge clk);
      mv_valid     = 1'b0;
      obs_err_start = err;
      obs_hs_start = satd_start;
      obs_hs_phase = satd_phase;
      obs_h_ctr_x  = int'(ctr_x);
      obs_h_ctr_y  = int'(ctr_y);
      if (done_in_start) begin
         best_done = 1'b1;
         best      = 4'd0;
      end
      @(posedge clk);
      @(negedge clk);
      best_done = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
         if (i == hdel) begin
            best_done = 1'b1;
            best      = 4'(hb);
            @(posedge clk);
            @(negedge clk);
            best_done = 1'b0;
            break;
         end
         @(posedge clk);
         @(negedge clk);
      end
      obs_qs_start = satd_start;
      obs_qs_phase = satd_phase;
      obs_q_ctr_x  = int'(ctr_x);
      obs_q_ctr_y  = int'(ctr_y);
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < TIMEOUT; i++) begin
         if (i == qdel) begin
            best_done = 1'b1;
            best      = 4'(qb);
            @(posedge clk);
            @(negedge clk);
            best_done = 1'b0;
            break;
         end
         @(posedge clk);
         @(negedge clk);
      end
      k = 0;
      while (!mv_out_valid && k < 20) begin
         @(posedge clk);
         @(negedge clk);
         k++;
      end
      obs_valid  = mv_out_valid;
      obs_out_x  = int'(mv_out_x);
      obs_out_y  = int'(mv_out_y);
      obs_err    = err;
      obs_stable = 1'b1;
      for (int i = 0; i < rdel; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (!mv_out_valid || mv_ready || int'(mv_out_x) != obs_out_x ||
             int'(mv_out_y) != obs_out_y)
            obs_stable = 1'b0;
      end
      mv_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mv_out_ready    = 1'b0;
      obs_after_valid = mv_out_valid;
      obs_after_ready = mv_ready;
      obs_pulses      = pulse_cnt - p0;
   endtask

   task automatic test_reset();
      rst          = 1'b0;
      mv_valid     = 1'b0;
      mv_int_x     = '0;
      mv_int_y     = '0;
      best         = '0;
      best_done    = 1'b0;
      mv_out_ready = 1'b0;
      pulse_cnt    = 0;
      #1;
      tests_run++;
      if (mv_ready !== 1'b1 || satd_start !== 1'b0 || satd_phase !== 1'b0 ||
          mv_out_valid !== 1'b0 || err !== 1'b0 || mv_out_x !== '0 ||
          mv_out_y !== '0 || ctr_x !== '0 || ctr_y !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset: ready=%b start=%b phase=%b valid=%b err=%b out=(%0d,%0d) ctr=(%0d,%0d), want ready=1 rest 0",
                  mv_ready, satd_start, satd_phase, mv_out_valid, err,
                  mv_out_x, mv_out_y, ctr_x, ctr_y);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_centre();
      phase_q.delete();
      drive_job(3, -2, 4, 4, 0, 0, 0, 1'b0);
      tests_run++;
      if (obs_out_x != 12 || obs_out_y != -8 || !obs_valid || obs_err) begin
         tests_failed++;
         $display("[TB] FAIL centre_out: got (%0d,%0d) valid=%b err=%b, want (12,-8) valid=1 err=0",
                  obs_out_x, obs_out_y, obs_valid, obs_err);
      end
      tests_run++;
      if (obs_pulses != 2 || phase_q.size() != 2 || phase_q[0] != 1'b0 || phase_q[1] != 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL centre_pulses: got %0d pulses (%0d phases logged), want 2 with phase 0 then 1",
                  obs_pulses, phase_q.size());
      end
      tests_run++;
      if (obs_after_valid || !obs_after_ready) begin
         tests_failed++;
         $display("[TB] FAIL centre_handshake: after accept valid=%b ready=%b, want 0/1",
                  obs_after_valid, obs_after_ready);
      end
   endtask

   task automatic test_diag();
      drive_job(0, 0, 8, 0, 0, 0, 0, 1'b0);
      tests_run++;
      if (obs_q_ctr_x != 2 || obs_q_ctr_y != 2 || !obs_qs_start || !obs_qs_phase) begin
         tests_failed++;
         $display("[TB] FAIL diag_qctr: got (%0d,%0d) start=%b phase=%b, want (2,2) start=1 phase=1",
                  obs_q_ctr_x, obs_q_ctr_y, obs_qs_start, obs_qs_phase);
      end
      tests_run++;
      if (obs_out_x != 1 || obs_out_y != 1) begin
         tests_failed++;
         $display("[TB] FAIL diag_out: got (%0d,%0d), want (1,1)", obs_out_x, obs_out_y);
      end
      drive_job(-5, 7, 3, 5, 0, 0, 0, 1'b0);
      tests_run++;
      if (obs_out_x != -21 || obs_out_y != 28 || obs_err) begin
         tests_failed++;
         $display("[TB] FAIL mixed_out: got (%0d,%0d) err=%b, want (-21,28) err=0",
                  obs_out_x, obs_out_y, obs_err);
      end
   endtask

   task automatic test_random();
      int mx, my, hb, qb, hd, qd, ex, ey, bad;
      bad = 0;
      for (int n = 0; n < 25; n++) begin
         mx = int'($urandom_range(0, 1023)) - 512;
         my = int'($urandom_range(0, 1023)) - 512;
         hb = int'($urandom_range(0, 8));
         qb = int'($urandom_range(0, 8));
         hd = int'($urandom_range(0, 3));
         qd = int'($urandom_range(0, 3));
         drive_job(mx, my, hb, qb, hd, qd, int'($urandom_range(0, 2)), 1'b0);
         ex = 4 * mx + 2 * off_x(hb) + off_x(qb);
         ey = 4 * my + 2 * off_y(hb) + off_y(qb);
         tests_run++;
         if (obs_out_x != ex || obs_out_y != ey || obs_err || !obs_stable ||
             obs_h_ctr_x != 4 * mx || obs_h_ctr_y != 4 * my ||
             obs_q_ctr_x != 4 * mx + 2 * off_x(hb) || obs_q_ctr_y != 4 * my + 2 * off_y(hb)) begin
            tests_failed++;
            bad++;
            $display("[TB] FAIL random[%0d]: mv=(%0d,%0d) hb=%0d qb=%0d got out=(%0d,%0d) err=%b hctr=(%0d,%0d) qctr=(%0d,%0d), want out=(%0d,%0d) err=0",
                     n, mx, my, hb, qb, obs_out_x, obs_out_y, obs_err,
                     obs_h_ctr_x, obs_h_ctr_y, obs_q_ctr_x, obs_q_ctr_y, ex, ey);
         end
      end
   endtask

   task automatic test_timeout();
      drive_job(-9, 4, 0, 7, TIMEOUT, 0, 0, 1'b1);
      tests_run++;
      if (!obs_qs_start || !obs_qs_phase || obs_q_ctr_x != -36 || obs_q_ctr_y != 16) begin
         tests_failed++;
         $display("[TB] FAIL timeout_qstart: start=%b phase=%b ctr=(%0d,%0d), want 1/1 (-36,16)",
                  obs_qs_start, obs_qs_phase, obs_q_ctr_x, obs_q_ctr_y);
      end
      tests_run++;
      if (obs_out_x != -36 || obs_out_y != 17 || !obs_err) begin
         tests_failed++;
         $display("[TB] FAIL timeout_out: got (%0d,%0d) err=%b, want (-36,17) err=1",
                  obs_out_x, obs_out_y, obs_err);
      end
   endtask

   task automatic test_illegal();
      drive_job(100, -100, 12, 2, 1, 0, 0, 1'b0);
      tests_run++;
      if (obs_out_x != 401 || obs_out_y != -401 || !obs_err) begin
         tests_failed++;
         $display("[TB] FAIL illegal_out: got (%0d,%0d) err=%b, want (401,-401) err=1",
                  obs_out_x, obs_out_y, obs_err);
      end
      drive_job(1, 1, 4, 4, 0, 0, 0, 1'b0);
      tests_run++;
      if (obs_err_start || obs_err || obs_out_x != 4 || obs_out_y != 4) begin
         tests_failed++;
         $display("[TB] FAIL illegal_clear: err at start=%b end=%b out=(%0d,%0d), want 0/0 (4,4)",
                  obs_err_start, obs_err, obs_out_x, obs_out_y);
      end
   endtask

   task automatic test_backpressure_reset();
      int p0;
      drive_job(511, -512, 8, 0, 0, 0, 10, 1'b0);
      tests_run++;
      if (!obs_stable || obs_out_x != 2045 || obs_out_y != -2049 + 2) begin
         tests_failed++;
         $display("[TB] FAIL backpressure: stable=%b out=(%0d,%0d), want stable=1 (2045,-2047)",
                  obs_stable, obs_out_x, obs_out_y);
      end
      @(negedge clk);
      mv_valid = 1'b1;
      mv_int_x = 10'sd20;
      mv_int_y = 10'sd20;
      @(posedge clk);
      @(negedge clk);
      mv_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      best_done = 1'b1;
      best      = 4'd4;
      @(posedge clk);
      @(negedge clk);
      best_done = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if (mv_ready !== 1'b1 || mv_out_valid !== 1'b0 || satd_start !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL midreset: ready=%b valid=%b start=%b, want 1/0/0",
                  mv_ready, mv_out_valid, satd_start);
      end
      p0 = pulse_cnt;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      tests_run++;
      if (pulse_cnt != p0 || mv_ready !== 1'b1 || mv_out_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL postreset: extra pulses=%0d ready=%b valid=%b, want 0/1/0",
                  pulse_cnt - p0, mv_ready, mv_out_valid);
      end
      drive_job(-1, 2, 1, 6, 0, 2, 0, 1'b0);
      tests_run++;
      if (obs_out_x != -5 || obs_out_y != 7 || obs_err) begin
         tests_failed++;
         $display("[TB] FAIL recover: got (%0d,%0d) err=%b, want (-5,7) err=0",
                  obs_out_x, obs_out_y, obs_err);
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_centre();
      test_diag();
      test_random();
      test_timeout();
      test_illegal();
      test_backpressure_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
